// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode, condition-code and NZCV constants
package alu_pkg;

  typedef logic [3:0] nzcv_t;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  localparam logic [3:0] OP_ADC   = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_SUB   = 4'd5;
  localparam logic [3:0] OP_SBC   = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_RSB   = 4'd8;
  localparam logic [3:0] OP_NOT   = 4'd9;
  localparam logic [3:0] OP_DIV   = 4'd10;
  localparam logic [3:0] OP_MOD   = 4'd11;
  localparam logic [3:0] OP_SHIFT = 4'd12;
  localparam logic [3:0] OP_LOR   = 4'd13;
  localparam logic [3:0] OP_LAND  = 4'd14;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  localparam nzcv_t MASK_ALL  = 4'b1111;
  localparam nzcv_t MASK_NZ   = 4'b1100;
  localparam nzcv_t MASK_V    = 4'b0001;
  localparam nzcv_t MASK_NONE = 4'b0000;

endpackage

// File: rtl/nzcv_stack.sv
// rtl/nzcv_stack.sv - bounded LIFO of NZCV snapshots with sticky overflow/underflow error
module nzcv_stack
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  nzcv_t                   din,
  output nzcv_t                   top,
  output logic                    pop_ok,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  nzcv_t          mem [DEPTH];
  logic           empty;
  logic           full;
  logic [CW-1:0]  count_dec;
  logic [AW-1:0]  top_idx;
  logic [AW-1:0]  wr_idx;
  logic           mem_we;
  logic [AW-1:0]  mem_widx;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign count_dec = count - 1'b1;
  assign top_idx   = count_dec[AW-1:0];
  assign wr_idx    = count[AW-1:0];
  assign top       = mem[top_idx];
  assign pop_ok    = pop && !empty;

  // Simultaneous push+pop swaps the top slot in place instead of moving the pointer.
  always_comb begin
    mem_we   = 1'b0;
    mem_widx = wr_idx;
    if (push && pop) begin
      mem_we   = !empty;
      mem_widx = top_idx;
    end else if (push) begin
      mem_we   = !full;
      mem_widx = wr_idx;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_widx] <= din;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
      err   <= 1'b0;
    end else if (push && pop) begin
      if (empty) begin
        err <= 1'b1;
      end
    end else if (pop) begin
      if (empty) begin
        err <= 1'b1;
      end else begin
        count <= count_dec;
      end
    end else if (push) begin
      if (full) begin
        err <= 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_status_unit.sv
// rtl/alu_status_unit.sv - NZCV flag register, carry feedback, condition evaluation and shadow stack
module alu_status_unit
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    Negative,
  input  logic                    Zero,
  input  logic                    Carry,
  input  logic                    oVerflow,
  input  logic [3:0]              alu_control,
  input  logic                    update_en,
  input  logic                    flag_wr,
  input  logic [3:0]              flag_wdata,
  input  logic                    push,
  input  logic                    pop,
  input  logic [3:0]              cond,
  input  logic                    cond_valid,
  output logic [3:0]              nzcv,
  output logic                    CarryIn,
  output logic                    cond_pass,
  output logic                    cond_done,
  output logic [$clog2(DEPTH):0]  stack_count,
  output logic                    stack_err
);

  function automatic nzcv_t write_mask(input logic [3:0] op);
    nzcv_t m;
    case (op)
      OP_ADC, OP_ADD, OP_SUB, OP_SBC, OP_RSB: m = MASK_ALL;
      OP_DIV, OP_MOD:                         m = MASK_V;
      OP_SHIFT:                               m = MASK_NONE;
      default:                                m = MASK_NZ;
    endcase
    return m;
  endfunction

  function automatic logic cond_eval(input logic [3:0] c, input nzcv_t f);
    logic n, z, cy, v, r;
    n  = f[NZCV_N];
    z  = f[NZCV_Z];
    cy = f[NZCV_C];
    v  = f[NZCV_V];
    case (c)
      COND_EQ: r = z;
      COND_NE: r = !z;
      COND_CS: r = cy;
      COND_CC: r = !cy;
      COND_MI: r = n;
      COND_PL: r = !n;
      COND_VS: r = v;
      COND_VC: r = !v;
      COND_HI: r = cy && !z;
      COND_LS: r = !cy || z;
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = !z && (n == v);
      COND_LE: r = z || (n != v);
      COND_AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  nzcv_t  alu_flags;
  nzcv_t  mask;
  nzcv_t  stack_top;
  logic   pop_ok;
  nzcv_t  nzcv_next;

  assign alu_flags = {Negative, Zero, Carry, oVerflow};
  assign mask      = write_mask(alu_control);
  assign CarryIn   = nzcv[NZCV_C];

  nzcv_stack #(
    .DEPTH (DEPTH)
  ) u_stack (
    .clock  (clock),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .din    (nzcv),
    .top    (stack_top),
    .pop_ok (pop_ok),
    .count  (stack_count),
    .err    (stack_err)
  );

  // A failed pop (empty stack) falls through so lower-priority writes still land.
  always_comb begin
    nzcv_next = nzcv;
    if (pop_ok) begin
      nzcv_next = stack_top;
    end else if (flag_wr) begin
      nzcv_next = flag_wdata;
    end else if (update_en) begin
      nzcv_next = (nzcv & ~mask) | (alu_flags & mask);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      nzcv      <= '0;
      cond_pass <= 1'b0;
      cond_done <= 1'b0;
    end else begin
      nzcv      <= nzcv_next;
      cond_done <= cond_valid;
      if (cond_valid) begin
        cond_pass <= cond_eval(cond, nzcv);
      end
    end
  end

endmodule

// File: tb/tb_alu_status_unit.sv
// tb/tb_alu_status_unit.sv - scoreboard bench for alu_status_unit against a queue-based flag model
module tb_alu_status_unit;

  localparam int DEPTH = 4;

  logic        clock;
  logic        reset;
  logic        Negative, Zero, Carry, oVerflow;
  logic [3:0]  alu_control;
  logic        update_en;
  logic        flag_wr;
  logic [3:0]  flag_wdata;
  logic        push, pop;
  logic [3:0]  cond;
  logic        cond_valid;
  logic [3:0]  nzcv;
  logic        CarryIn;
  logic        cond_pass;
  logic        cond_done;
  logic [2:0]  stack_count;
  logic        stack_err;

  alu_status_unit #(.DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .Negative    (Negative),
    .Zero        (Zero),
    .Carry       (Carry),
    .oVerflow    (oVerflow),
    .alu_control (alu_control),
    .update_en   (update_en),
    .flag_wr     (flag_wr),
    .flag_wdata  (flag_wdata),
    .push        (push),
    .pop         (pop),
    .cond        (cond),
    .cond_valid  (cond_valid),
    .nzcv        (nzcv),
    .CarryIn     (CarryIn),
    .cond_pass   (cond_pass),
    .cond_done   (cond_done),
    .stack_count (stack_count),
    .stack_err   (stack_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] nzcv;
    logic [2:0] cnt;
    logic       err;
    logic       done;
    logic       pass;
  } exp_t;

  exp_t       state_q[$];
  logic       cond_q[$];
  logic [3:0] m_stack[$];
  logic [3:0] m_nzcv;
  logic       m_err, m_pass, m_done;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      0: return z;             1: return !z;
      2: return cy;            3: return !cy;
      4: return n;             5: return !n;
      6: return v;             7: return !v;
      8: return cy & !z;       9: return !cy | z;
      10: return n == v;       11: return n != v;
      12: return !z & (n == v); 13: return z | (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // One clock cycle: advance the model from the current inputs, then queue the expectation.
  task automatic step();
    exp_t       e;
    logic [3:0] cur, top;
    logic       took_pop, want_cond;
    logic       wr_nz, wr_c, wr_v;
    int         op;
    want_cond = 1'b0;
    if (!reset) begin
      m_stack.delete();
      m_nzcv = 4'b0; m_err = 1'b0; m_pass = 1'b0; m_done = 1'b0;
    end else begin
      cur = m_nzcv; top = 4'b0; took_pop = 1'b0;
      m_done = cond_valid;
      if (cond_valid) begin
        m_pass = cond_model(cond, cur);
        want_cond = 1'b1;
      end
      if (push && pop) begin
        if (m_stack.size() == 0) m_err = 1'b1;
        else begin
          top = m_stack[m_stack.size()-1];
          m_stack[m_stack.size()-1] = cur;
          took_pop = 1'b1;
        end
      end else if (pop) begin
        if (m_stack.size() == 0) m_err = 1'b1;
        else begin top = m_stack.pop_back(); took_pop = 1'b1; end
      end else if (push) begin
        if (m_stack.size() == DEPTH) m_err = 1'b1;
        else m_stack.push_back(cur);
      end
      op    = int'(alu_control);
      wr_nz = !(op == 10 || op == 11 || op == 12);
      wr_c  = (op == 1 || op == 2 || op == 5 || op == 6 || op == 8);
      wr_v  = wr_c || op == 10 || op == 11;
      if (took_pop) m_nzcv = top;
      else if (flag_wr) m_nzcv = flag_wdata;
      else if (update_en)
        m_nzcv = {wr_nz ? Negative : cur[3], wr_nz ? Zero : cur[2],
                  wr_c ? Carry : cur[1], wr_v ? oVerflow : cur[0]};
    end
    e.nzcv = m_nzcv; e.cnt = 3'(m_stack.size()); e.err = m_err;
    e.done = m_done; e.pass = m_pass;
    @(posedge clock);
    state_q.push_back(e);
    if (want_cond) cond_q.push_back(m_pass);
    #1;
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (state_q.size() > 0) begin
      e = state_q.pop_front();
      check("nzcv", 32'(nzcv), 32'(e.nzcv));
      check("carry_in", 32'(CarryIn), 32'(e.nzcv[1]));
      check("stack_count", 32'(stack_count), 32'(e.cnt));
      check("stack_err", 32'(stack_err), 32'(e.err));
      check("cond_done", 32'(cond_done), 32'(e.done));
      check("cond_pass_hold", 32'(cond_pass), 32'(e.pass));
    end
    if (cond_done === 1'b1) begin
      if (cond_q.size() == 0) check("cond_unexpected", 32'(cond_done), 32'd0);
      else check("cond_result", 32'(cond_pass), 32'(cond_q.pop_front()));
    end
  end

  task automatic idle();
    reset = 1'b1; Negative = 0; Zero = 0; Carry = 0; oVerflow = 0;
    alu_control = 4'd0; update_en = 0; flag_wr = 0; flag_wdata = 4'd0;
    push = 0; pop = 0; cond = 4'd0; cond_valid = 0;
  endtask

  task automatic do_reset();
    idle(); reset = 1'b0; step(); idle();
  endtask

  task automatic set_flags(input logic [3:0] f);
    {Negative, Zero, Carry, oVerflow} = f;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] sweep;
    sweep = 16'h565A;
    idle();
    do_reset();
    check("reset_nzcv", 32'(nzcv), 32'h0);
    check("reset_count", 32'(stack_count), 32'h0);
    check("reset_err", 32'(stack_err), 32'h0);
    check("reset_done", 32'(cond_done), 32'h0);
    check("reset_pass", 32'(cond_pass), 32'h0);

    update_en = 1; alu_control = 4'd2; set_flags(4'b0110); step();
    check("arith_update", 32'(nzcv), 32'h6);
    check("arith_carry_in", 32'(CarryIn), 32'h1);
    alu_control = 4'd3; set_flags(4'b1001); step();
    check("nz_mask", 32'(nzcv), 32'hA);
    alu_control = 4'd10; set_flags(4'b0101); step();
    check("v_mask", 32'(nzcv), 32'hB);
    alu_control = 4'd12; set_flags(4'b0100); step();
    check("none_mask", 32'(nzcv), 32'hB);
    idle();

    flag_wr = 1; flag_wdata = 4'b1001; step(); idle();
    for (int i = 0; i < 16; i++) begin
      cond_valid = 1; cond = 4'(i); step();
      check($sformatf("sweep_done_%0d", i), 32'(cond_done), 32'h1);
      check($sformatf("sweep_pass_%0d", i), 32'(cond_pass), 32'(sweep[i]));
    end
    idle();

    flag_wr = 1; flag_wdata = 4'b0000; step(); idle();
    cond_valid = 1; cond = 4'd0; update_en = 1; alu_control = 4'd2; set_flags(4'b0100); step();
    check("race_pass", 32'(cond_pass), 32'h0);
    check("race_nzcv", 32'(nzcv), 32'h4);
    idle();

    do_reset();
    flag_wr = 1; flag_wdata = 4'd1; step();
    for (int k = 2; k <= 6; k++) begin
      push = 1; flag_wr = 1; flag_wdata = 4'(k); step();
    end
    idle();
    check("full_count", 32'(stack_count), 32'h4);
    check("overflow_err", 32'(stack_err), 32'h1);
    for (int k = 4; k >= 1; k--) begin
      pop = 1; step();
      check($sformatf("lifo_%0d", k), 32'(nzcv), 32'(k));
    end
    pop = 1; step(); idle();
    check("underflow_nzcv", 32'(nzcv), 32'h1);
    check("underflow_count", 32'(stack_count), 32'h0);

    flag_wr = 1; flag_wdata = 4'b1100; step();
    push = 1; flag_wdata = 4'b0000; step(); idle();
    pop = 1; flag_wr = 1; flag_wdata = 4'b0011; update_en = 1; alu_control = 4'd2;
    set_flags(4'b1111); step(); idle();
    check("priority_pop", 32'(nzcv), 32'hC);
    push = 1; step();
    check("pre_reset_count", 32'(stack_count), 32'h1);
    cond_valid = 1; reset = 0; step(); idle();
    check("reset_push_count", 32'(stack_count), 32'h0);
    check("reset_push_err", 32'(stack_err), 32'h0);
    check("reset_cond_done", 32'(cond_done), 32'h0);

    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(0, 99) >= 2);
      set_flags(4'($urandom_range(0, 15)));
      alu_control = 4'($urandom_range(0, 15));
      update_en   = ($urandom_range(0, 1) == 1);
      flag_wr     = ($urandom_range(0, 99) < 15);
      flag_wdata  = 4'($urandom_range(0, 15));
      push        = ($urandom_range(0, 99) < 30);
      pop         = ($urandom_range(0, 99) < 25);
      cond        = 4'($urandom_range(0, 15));
      cond_valid  = ($urandom_range(0, 99) < 60);
      step();
    end
    idle();
    step();
    @(negedge clock);
    #1;
    check("state_q_drained", 32'(state_q.size()), 32'd0);
    check("cond_q_drained", 32'(cond_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
